// File: rtl/cam_pkg.sv
// Shared definitions for the camera write path: capture FSM states, default
// image geometry, counter widths and the RGB444 packing helper.
package cam_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      CAPTURE = 2'd2
   } cam_state_t;

   localparam int IMAGE_WIDTH  = 160;
   localparam int IMAGE_HEIGHT = 140;
   localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

   localparam int RGB_FIELD_W  = 4;
   localparam int PIXEL_W      = 3 * RGB_FIELD_W;

   localparam int PX_W = 11;
   localparam int LN_W = 10;
   localparam logic [PX_W-1:0] PX_MAX = '1;
   localparam logic [LN_W-1:0] LN_MAX = '1;

   // The first byte of a pixel carries red in its low nibble; the second
   // byte carries green in the high nibble and blue in the low nibble.
   function automatic logic [PIXEL_W-1:0] pack_rgb444(
      input logic [RGB_FIELD_W-1:0] red,
      input logic [7:0]             green_blue
   );
      return {red, green_blue};
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers the camera framing signals once in the clk_in domain and flags
// their edges against the previous registered value.
//   clk_in, reset          : clock, synchronous active-high reset
//   vsync, href            : framing inputs (already in the clk_in domain)
//   vsync_q, href_q        : registered levels
//   vsync_rise/vsync_fall  : one-cycle edge pulses aligned with vsync_q
//   href_rise/href_fall    : one-cycle edge pulses aligned with href_q
module sync_edge_detect (
   input  logic clk_in,
   input  logic reset,
   input  logic vsync,
   input  logic href,
   output logic vsync_q,
   output logic href_q,
   output logic vsync_rise,
   output logic vsync_fall,
   output logic href_rise,
   output logic href_fall
);

   logic vsync_d;
   logic href_d;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         vsync_q <= 1'b0;
         vsync_d <= 1'b0;
         href_q  <= 1'b0;
         href_d  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         vsync_d <= vsync_q;
         href_q  <= href;
         href_d  <= href_q;
      end
   end

   assign vsync_rise = vsync_q & ~vsync_d;
   assign vsync_fall = ~vsync_q & vsync_d;
   assign href_rise  = href_q & ~href_d;
   assign href_fall  = ~href_q & href_d;

endmodule

// File: rtl/camera_frame_writer.sv
// Camera byte stream to image memory writer. Assembles RGB444 pixels from
// byte pairs, crops a fixed window and writes it to linear addresses.
//   clk_in, reset    : clock, synchronous active-high reset
//   capture_en       : capture permission, looked at on the vsync fall only
//   cam_vsync/href   : frame / line framing
//   cam_valid/data   : byte strobe and camera byte
//   write_address/data/en : image memory write port
//   frame_done       : one-cycle pulse when a captured frame ends
//   busy             : high while capturing
//
// state   | meaning
// IDLE    | after reset, waiting for vsync high so no partial frame is taken
// SYNC    | between frames, waiting for the vsync fall
// CAPTURE | frame active, pixels stored until the next vsync rise
module camera_frame_writer
   import cam_pkg::*;
#(
   parameter int image_width  = IMAGE_WIDTH,
   parameter int image_height = IMAGE_HEIGHT,
   parameter int data_size    = 11,
   parameter int address_size = 14,
   parameter int x_offset     = 0,
   parameter int y_offset     = 0
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  capture_en,
   input  logic                  cam_vsync,
   input  logic                  cam_href,
   input  logic                  cam_valid,
   input  logic [7:0]            cam_data,
   output logic [address_size:0] write_address,
   output logic [data_size:0]    write_data,
   output logic                  write_en,
   output logic                  frame_done,
   output logic                  busy
);

   localparam logic [address_size:0] FRAME_END = (address_size+1)'(image_width * image_height);

   cam_state_t state, state_next;
   logic start_frame, end_frame;

   logic vsync_q, href_q, vsync_rise, vsync_fall, href_rise, href_fall;
   logic valid_q;
   logic [7:0] data_q;

   logic byte_phase, phase_now;
   logic [RGB_FIELD_W-1:0] red_hold;
   logic [PX_W-1:0] px, px_now;
   logic [LN_W-1:0] ln;
   logic [address_size:0] addr;
   logic byte_take, pixel_done, in_window, store;

   sync_edge_detect u_sync (
      .clk_in     (clk_in),
      .reset      (reset),
      .vsync      (cam_vsync),
      .href       (cam_href),
      .vsync_q    (vsync_q),
      .href_q     (href_q),
      .vsync_rise (vsync_rise),
      .vsync_fall (vsync_fall),
      .href_rise  (href_rise),
      .href_fall  (href_fall)
   );

   always_ff @(posedge clk_in) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      busy        = (state == CAPTURE);
      case (state)
         IDLE: begin
            if (vsync_q) state_next = SYNC;
         end
         SYNC: begin
            if (vsync_fall && capture_en) begin
               state_next  = CAPTURE;
               start_frame = 1'b1;
            end
         end
         CAPTURE: begin
            if (vsync_rise) begin
               state_next = SYNC;
               end_frame  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A byte arriving in the same cycle as the href rise is the first byte of
   // the line, so the line-start clear must be visible to it immediately.
   assign phase_now  = href_rise ? 1'b0 : byte_phase;
   assign px_now     = href_rise ? '0 : px;
   assign byte_take  = (state == CAPTURE) && valid_q && href_q;
   assign pixel_done = byte_take && phase_now;
   assign in_window  = (int'(px_now) >= x_offset) && (int'(px_now) < x_offset + image_width) &&
                       (int'(ln) >= y_offset) && (int'(ln) < y_offset + image_height);
   assign store      = pixel_done && in_window && (addr < FRAME_END);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         valid_q       <= 1'b0;
         data_q        <= '0;
         byte_phase    <= 1'b0;
         red_hold      <= '0;
         px            <= '0;
         ln            <= '0;
         addr          <= '0;
         write_en      <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         frame_done    <= 1'b0;
      end else begin
         valid_q    <= cam_valid;
         data_q     <= cam_data;
         write_en   <= store;
         frame_done <= end_frame;
         if (start_frame) begin
            byte_phase <= 1'b0;
            px         <= '0;
            ln         <= '0;
            addr       <= '0;
         end else if (state == CAPTURE) begin
            if (href_fall && ln != LN_MAX) ln <= ln + 1'b1;
            if (href_rise) begin
               px         <= '0;
               byte_phase <= 1'b0;
            end
            if (byte_take) begin
               byte_phase <= ~phase_now;
               if (!phase_now)             red_hold <= data_q[3:0];
               else if (px_now != PX_MAX)  px       <= px_now + 1'b1;
            end
            if (store) begin
               write_address <= addr;
               write_data    <= pack_rgb444(red_hold, data_q);
               addr          <= addr + 1'b1;
            end
         end
      end
   end

endmodule
